usb_rx_bit_decoder: RTL

Receive-side bit decoder directly downstream of the DPPL clock-recovery stage. It runs in the clk48 domain and turns each rising edge of the recovered `readCLK12` into one bit strobe, sampling the synchronized line state at that strobe. It performs NRZI decoding, SYNC detection, bit unstuffing, LSB-first byte assembly and EOP detection. Its output is a byte stream with packet-level status for the packet decoder.

---
 rtl/usb_rx_pkg.sv | 17 +
 rtl/usb_rx_unstuffer.sv | 47 ++++
 rtl/usb_rx_bit_decoder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive bit decoder.
package usb_rx_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSync,
      StData,
      StEop,
      StAbort
   } rx_dec_state_t;

   localparam logic LINE_J = 1'b1;
   localparam logic LINE_K = 1'b0;

   localparam int unsigned MAX_ONES_DEFAULT = 6;

endpackage

// File: rtl/usb_rx_unstuffer.sv
// Tracks runs of decoded 1s and flags the bit that must be a stuffed 0.
module usb_rx_unstuffer
   import usb_rx_pkg::*;
#(
   parameter int unsigned MAX_ONES = MAX_ONES_DEFAULT
) (
   input  logic clk48,
   input  logic RST_N,
   input  logic stb,
   input  logic d,
   input  logic clear,
   output logic bitValid,
   output logic stuffErr
);

   localparam logic [3:0] MaxOnesC = 4'(MAX_ONES);

   logic [3:0] ones_q, ones_d;
   logic       at_limit;

   assign at_limit = (ones_q == MaxOnesC);
   assign bitValid = stb & ~at_limit;
   assign stuffErr = stb & at_limit & d;

   always_comb begin
      ones_d = ones_q;
      // The 1 that ends SYNC already counts toward the first run.
      if (clear) begin
         ones_d = 4'd1;
      end else if (stb) begin
         if (at_limit || !d) begin
            ones_d = 4'd0;
         end else begin
            ones_d = ones_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk48 or negedge RST_N) begin
      if (!RST_N) begin
         ones_q <= 4'd0;
      end else begin
         ones_q <= ones_d;
      end
   end

endmodule

// File: rtl/usb_rx_bit_decoder.sv
// USB receive bit decoder: NRZI decode, SYNC detect, unstuffing, byte assembly and EOP detect.
module usb_rx_bit_decoder
   import usb_rx_pkg::*;
#(
   parameter int unsigned SYNC_MIN_ZEROS = 5,
   parameter int unsigned MAX_ONES       = MAX_ONES_DEFAULT
) (
   input  logic       clk48,
   input  logic       RST_N,
   input  logic       readCLK12,
   input  logic       dataRecv,
   input  logic       se0,
   output logic       rxActive,
   output logic [7:0] rxByte,
   output logic       rxByteValid,
   output logic       eopDetected,
   output logic       rxError
);

   localparam logic [2:0] SyncMinC = 3'(SYNC_MIN_ZEROS);

   rx_dec_state_t state_q, state_d;
   logic       read_clk_q, prev_level_q;
   logic [2:0] zero_cnt_q, zero_cnt_d, bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d, byte_q, byte_d;
   logic       partial_q, partial_d, abort_se0_q, abort_se0_d;
   logic       active_q, active_d, valid_q, valid_d, eop_q, eop_d, err_q, err_d;
   logic       stb, d_bit, sync_ok, us_stb, bit_valid, stuff_err;

   assign stb     = readCLK12 & ~read_clk_q;
   assign d_bit   = (dataRecv == prev_level_q);
   assign sync_ok = stb & (state_q == StSync) & ~se0 & d_bit & (zero_cnt_q >= SyncMinC);
   assign us_stb  = stb & (state_q == StData) & ~se0;

   usb_rx_unstuffer #(
      .MAX_ONES(MAX_ONES)
   ) u_unstuffer (
      .clk48   (clk48),
      .RST_N   (RST_N),
      .stb     (us_stb),
      .d       (d_bit),
      .clear   (sync_ok),
      .bitValid(bit_valid),
      .stuffErr(stuff_err)
   );

   always_comb begin
      state_d     = state_q;
      zero_cnt_d  = zero_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      byte_d      = byte_q;
      partial_d   = partial_q;
      abort_se0_d = abort_se0_q;
      active_d    = active_q;
      valid_d     = 1'b0;
      eop_d       = 1'b0;
      err_d       = 1'b0;
      if (stb) begin
         case (state_q)
            StIdle: begin
               if (!se0 && !d_bit) begin
                  state_d    = StSync;
                  zero_cnt_d = 3'd1;
               end
            end
            StSync: begin
               if (se0) begin
                  state_d = StIdle;
               end else if (!d_bit) begin
                  if (zero_cnt_q != 3'd7) zero_cnt_d = zero_cnt_q + 3'd1;
               end else if (sync_ok) begin
                  state_d   = StData;
                  active_d  = 1'b1;
                  bit_cnt_d = 3'd0;
                  partial_d = 1'b0;
               end else begin
                  state_d = StIdle;
               end
            end
            StData: begin
               if (se0) begin
                  // Partial-byte error is reported together with the EOP pulse.
                  state_d   = StEop;
                  partial_d = (bit_cnt_q != 3'd0);
               end else if (stuff_err) begin
                  state_d     = StAbort;
                  err_d       = 1'b1;
                  active_d    = 1'b0;
                  abort_se0_d = 1'b0;
               end else if (bit_valid) begin
                  shift_d   = {d_bit, shift_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     byte_d  = {d_bit, shift_q[7:1]};
                     valid_d = 1'b1;
                  end
               end
            end
            StEop: begin
               if (!se0) begin
                  active_d = 1'b0;
                  if (dataRecv == LINE_J) begin
                     state_d = StIdle;
                     eop_d   = 1'b1;
                     err_d   = partial_q;
                  end else begin
                     state_d     = StAbort;
                     err_d       = 1'b1;
                     abort_se0_d = 1'b0;
                  end
               end
            end
            StAbort: begin
               if (se0) begin
                  abort_se0_d = 1'b1;
               end else if (abort_se0_q && dataRecv == LINE_J) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk48 or negedge RST_N) begin
      if (!RST_N) begin
         read_clk_q   <= 1'b1;
         prev_level_q <= LINE_J;
         state_q      <= StIdle;
         zero_cnt_q   <= 3'd0;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 8'h00;
         byte_q       <= 8'h00;
         partial_q    <= 1'b0;
         abort_se0_q  <= 1'b0;
         active_q     <= 1'b0;
         valid_q      <= 1'b0;
         eop_q        <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         read_clk_q <= readCLK12;
         if (stb && !se0) prev_level_q <= dataRecv;
         state_q     <= state_d;
         zero_cnt_q  <= zero_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         byte_q      <= byte_d;
         partial_q   <= partial_d;
         abort_se0_q <= abort_se0_d;
         active_q    <= active_d;
         valid_q     <= valid_d;
         eop_q       <= eop_d;
         err_q       <= err_d;
      end
   end

   assign rxActive    = active_q;
   assign rxByte      = byte_q;
   assign rxByteValid = valid_q;
   assign eopDetected = eop_q;
   assign rxError     = err_q;

endmodule
